mmio_ctrl: RTL and testbench
============================

// Module: mmio_ctrl
// PURPOSE
//  Memory-side neighbour of the pipelined RISC-V core. Consumes the core's E-stage mem_adr/mem_wdata/wea.
//  Decodes the address region, drives dmem/imem/bios BRAM ports, and owns memory-mapped IO:
//  UART TX FIFO, UART RX buffer, cycle and instret counters.
//  Returns M-stage read data (din) exactly one cycle after the address, matching BRAM read latency.
// PARAMETERS
//  TX_DEPTH  4   UART TX FIFO entries, power of 2 and >=2
//  AW        14  BRAM word-address width; port address = mem_adr[AW+1:2]
// PORTS
//  clk            in   1   clock
//  reset          in   1   reset, synchronous, active-high
//  mem_adr        in   32  core E-stage byte address
//  mem_wdata      in   32  store data, already lane-shifted by core
//  wea            in   4   byte write enables; 0 = no store
//  pc             in   32  core fetch PC; gates imem writes
//  instr_retire   in   1   one valid instruction retired this cycle
//  din            out  32  read data to core, valid cycle after mem_adr
//  dmem_addr/imem_addr/bios_addr  out  AW  BRAM word addresses = mem_adr[AW+1:2]
//  dmem_we/imem_we    out  4   BRAM byte write enables
//  dmem_wdata/imem_wdata  out  32  = mem_wdata
//  dmem_dout/bios_dout    in   32  BRAM sync read data
//  tx_data        out  8   UART TX byte
//  tx_valid       out  1   TX FIFO non-empty
//  tx_ready       in   1   UART accepts byte when tx_valid&tx_ready
//  rx_data        in   8   UART RX byte
//  rx_valid       in   1   UART has byte
//  rx_ready       out  1   controller pops RX byte when rx_valid&rx_ready
// BEHAVIOUR
//  Region = mem_adr[31:28]: 4'b0001 dmem(r/w), 4'b0010 imem(w only), 4'b0100 bios(r only), 4'b1000 IO.
//  Other codes: reads return 0, writes ignored.
//  dmem_we = wea when region dmem, else 0. imem_we = wea when region imem AND pc[30]=1, else 0.
//  Stores to bios or to unmapped space are dropped silently.
//  IO map, word-aligned; byte lanes ignored, any nonzero wea = write:
//   0x8000_0000 R  {30'b0, rx_buf_full, ~tx_full}
//   0x8000_0004 R  {24'b0, rx_buf}; read pops buffer (rx_buf_full<=0)
//   0x8000_0008 W  push mem_wdata[7:0] into TX FIFO; push while full is dropped
//   0x8000_0010 R  cycle_cnt
//   0x8000_0014 R  instret_cnt
//   0x8000_0018 W  any store clears both counters to 0
//  Read path: region and IO read value are registered at posedge (sel_q, io_q).
//   din = mux(sel_q): dmem_dout | bios_dout | io_q | 0. Load-to-din latency = 1 cycle.
//   Reading imem returns 0.
//  RX: 1-entry buffer rx_buf. rx_ready = ~rx_buf_full | pop_this_cycle.
//   Capture when rx_valid&rx_ready. Pop and capture in the same cycle: buffer keeps the new byte, full stays 1.
//  TX FIFO: pops when tx_valid&tx_ready. Push and pop in the same cycle when full: push accepted, count unchanged.
//   Pointers wrap mod TX_DEPTH.
//  cycle_cnt: +1 every cycle, 32-bit wrap. instret_cnt: +instr_retire, 32-bit wrap.
//   Clear store has priority over increment; the value next cycle is 0.
//  Reset, synchronous: cycle_cnt=0, instret_cnt=0, FIFO empty (tx_valid=0), rx_buf_full=0 (rx_ready=1),
//   sel_q=none (din=0), io_q=0. Write-enable outputs are combinational and carry no reset value.
//  Mid-operation reset discards queued TX bytes and any buffered RX byte.
// STRUCTURE
//  Shared defines header: region codes, IO offsets, SEL_* encodings.
//  Sub-module sync_fifo (WIDTH=8, DEPTH=TX_DEPTH) with full/empty and simultaneous push/pop.
//  Remaining logic is flat: decode, counters, RX buffer, read mux.
// TESTING
//  1. sw 0x1000_0010 data=0xDEADBEEF wea=4'hF, then lw same address -> dmem_we=F with dmem_addr=4; din=dmem_dout next cycle.
//  2. Store to 0x2000_0000: with pc=0x4000_0100 -> imem_we=F; with pc=0x1000_0000 -> imem_we=0.
//  3. Five back-to-back stores to 0x8000_0008 with tx_ready=0 -> 4 queued, 5th dropped, status bit0=0;
//     raise tx_ready -> bytes drained in order, then tx_valid=0.
//  4. rx_valid with byte 0x41 -> status bit1=1; lw 0x8000_0004 -> din=0x41 next cycle, status bit1=0 after.
//     Pop coincident with new byte 0x42 -> status bit1 stays 1, next read returns 0x42.
//  5. After reset, run 100 cycles with instr_retire on 60 of them -> reads 0x8000_0010=100(+read offset),
//     0x8000_0014=60; store to 0x8000_0018 -> both read 0 next.
//  6. Assert reset mid-TX with 3 bytes queued -> tx_valid=0, rx_ready=1, din=0 the cycle after reset.

Source files
------------

// File: rtl/mmio_ctrl_pkg.sv
// rtl/mmio_ctrl_pkg.sv - region codes, IO word offsets and read-select encoding
package mmio_ctrl_pkg;

  localparam logic [3:0] REGION_DMEM = 4'b0001;
  localparam logic [3:0] REGION_IMEM = 4'b0010;
  localparam logic [3:0] REGION_BIOS = 4'b0100;
  localparam logic [3:0] REGION_IO   = 4'b1000;

  // IO offsets as word indices within the IO region (byte address bits 27:2)
  localparam logic [25:0] IO_STATUS  = 26'h0;
  localparam logic [25:0] IO_RX_DATA = 26'h1;
  localparam logic [25:0] IO_TX_DATA = 26'h2;
  localparam logic [25:0] IO_CYCLE   = 26'h4;
  localparam logic [25:0] IO_INSTRET = 26'h5;
  localparam logic [25:0] IO_CNT_CLR = 26'h6;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DMEM,
    SEL_BIOS,
    SEL_IO
  } sel_e;

  function automatic sel_e region_sel(input logic [3:0] region);
    case (region)
      REGION_DMEM: return SEL_DMEM;
      REGION_BIOS: return SEL_BIOS;
      REGION_IO:   return SEL_IO;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// rtl/mmio_ctrl_if.sv - core-side memory bus between the pipeline and mmio_ctrl
interface mmio_ctrl_if;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [3:0]  wea;
  logic [31:0] din;

  modport master (output mem_adr, output mem_wdata, output wea, input din);
  modport slave  (input mem_adr, input mem_wdata, input wea, output din);
endinterface

// File: rtl/mmio_ctrl_sync_fifo.sv
// rtl/mmio_ctrl_sync_fifo.sv - synchronous FIFO with full/empty and same-cycle push/pop
module mmio_ctrl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - address decode, BRAM port steering, UART FIFOs and perf counters
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int AW       = 14
) (
  input  logic          clk,
  input  logic          reset,
  mmio_ctrl_if.slave    bus,
  input  logic [31:0]   pc,
  input  logic          instr_retire,
  output logic [AW-1:0] dmem_addr,
  output logic [AW-1:0] imem_addr,
  output logic [AW-1:0] bios_addr,
  output logic [3:0]    dmem_we,
  output logic [3:0]    imem_we,
  output logic [31:0]   dmem_wdata,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   dmem_dout,
  input  logic [31:0]   bios_dout,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready
);

  logic [3:0]  region;
  logic [25:0] io_idx;
  logic        is_io;
  logic        store;
  logic        rx_pop;
  logic        tx_push;
  logic        cnt_clr;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_buf_full;
  logic [7:0]  rx_buf;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [31:0] io_rdata;
  logic [31:0] io_q;
  sel_e        sel_q;
  logic        unused_bits;

  assign region  = bus.mem_adr[31:28];
  assign io_idx  = bus.mem_adr[27:2];
  assign is_io   = (region == REGION_IO);
  assign store   = |bus.wea;
  // Any non-store cycle addressing the RX data word counts as the read that pops it
  assign rx_pop  = is_io && io_idx == IO_RX_DATA && !store;
  assign tx_push = is_io && io_idx == IO_TX_DATA && store;
  assign cnt_clr = is_io && io_idx == IO_CNT_CLR && store;

  assign dmem_addr  = bus.mem_adr[AW+1:2];
  assign imem_addr  = bus.mem_adr[AW+1:2];
  assign bios_addr  = bus.mem_adr[AW+1:2];
  assign dmem_wdata = bus.mem_wdata;
  assign imem_wdata = bus.mem_wdata;
  assign dmem_we    = (region == REGION_DMEM) ? bus.wea : 4'h0;
  assign imem_we    = (region == REGION_IMEM && pc[30]) ? bus.wea : 4'h0;

  assign unused_bits = ^{pc[31], pc[29:0], bus.mem_adr[1:0]};

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_buf_full | rx_pop;

  mmio_ctrl_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus.mem_wdata[7:0]),
    .pop       (tx_valid & tx_ready),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_comb begin
    io_rdata = 32'h0;
    if (is_io) begin
      case (io_idx)
        IO_STATUS:  io_rdata = {30'b0, rx_buf_full, ~tx_full};
        IO_RX_DATA: io_rdata = {24'b0, rx_buf};
        IO_CYCLE:   io_rdata = cycle_cnt;
        IO_INSTRET: io_rdata = instret_cnt;
        default:    io_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= SEL_NONE;
      io_q        <= 32'h0;
      cycle_cnt   <= 32'h0;
      instret_cnt <= 32'h0;
      rx_buf_full <= 1'b0;
      rx_buf      <= 8'h0;
    end else begin
      sel_q       <= region_sel(region);
      io_q        <= io_rdata;
      cycle_cnt   <= cnt_clr ? 32'h0 : cycle_cnt + 32'd1;
      instret_cnt <= cnt_clr ? 32'h0 : instret_cnt + {31'b0, instr_retire};
      // A capture wins over a pop so the buffer stays full with the newer byte
      if (rx_valid && rx_ready) begin
        rx_buf      <= rx_data;
        rx_buf_full <= 1'b1;
      end else if (rx_pop) begin
        rx_buf_full <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.din = 32'h0;
    case (sel_q)
      SEL_DMEM: bus.din = dmem_dout;
      SEL_BIOS: bus.din = bios_dout;
      SEL_IO:   bus.din = io_q;
      default:  bus.din = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - directed and random stimulus against a queue-based reference model
module tb_mmio_ctrl;

  localparam int TX_DEPTH = 4;
  localparam int AW       = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc;
  logic          instr_retire;
  logic [AW-1:0] dmem_addr, imem_addr, bios_addr;
  logic [3:0]    dmem_we, imem_we;
  logic [31:0]   dmem_wdata, imem_wdata;
  logic [31:0]   dmem_dout, bios_dout;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;

  mmio_ctrl_if bus ();

  mmio_ctrl #(.TX_DEPTH(TX_DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pc           (pc),
    .instr_retire (instr_retire),
    .dmem_addr    (dmem_addr),
    .imem_addr    (imem_addr),
    .bios_addr    (bios_addr),
    .dmem_we      (dmem_we),
    .imem_we      (imem_we),
    .dmem_wdata   (dmem_wdata),
    .imem_wdata   (imem_wdata),
    .dmem_dout    (dmem_dout),
    .bios_dout    (bios_dout),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_cycles, m_instret, m_io;
  logic [3:0]  m_region;
  bit          m_rx_full;
  logic [7:0]  m_rx_byte;
  logic [7:0]  m_txq [$];
  bit          m_known = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit io_at(input logic [31:0] a, input int word);
    return a[31:28] == 4'h8 && 32'(a[27:2]) == word;
  endfunction

  function automatic logic [31:0] io_value(input logic [31:0] a);
    if (a[31:28] != 4'h8) return 32'h0;
    case (32'(a[27:2]))
      0: return {30'b0, m_rx_full, m_txq.size() < TX_DEPTH};
      1: return {24'b0, m_rx_byte};
      4: return m_cycles;
      5: return m_instret;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] a;
    logic [31:0] io_now;
    bit wr, pop_tx, push_tx, rd_rx, ready, cap, clr, was_full;
    if (reset) begin
      m_cycles = 0; m_instret = 0; m_io = 0; m_region = 4'h0;
      m_rx_full = 0; m_rx_byte = 8'h0; m_txq.delete();
      m_known = 1;
      return;
    end
    a       = bus.mem_adr;
    wr      = bus.wea != 4'h0;
    io_now  = io_value(a);
    pop_tx  = m_txq.size() > 0 && tx_ready;
    push_tx = io_at(a, 2) && wr;
    rd_rx   = io_at(a, 1) && !wr;
    ready   = !m_rx_full || rd_rx;
    cap     = rx_valid && ready;
    clr     = io_at(a, 6) && wr;
    was_full = m_txq.size() == TX_DEPTH;
    if (pop_tx) void'(m_txq.pop_front());
    if (push_tx && (!was_full || pop_tx)) m_txq.push_back(bus.mem_wdata[7:0]);
    if (cap) begin
      m_rx_byte = rx_data;
      m_rx_full = 1;
    end else if (rd_rx) begin
      m_rx_full = 0;
    end
    m_cycles  = clr ? 32'h0 : m_cycles + 32'd1;
    m_instret = clr ? 32'h0 : m_instret + 32'(instr_retire);
    m_region  = a[31:28];
    m_io      = io_now;
  endtask

  task automatic cyc();
    logic [31:0] a;
    logic [31:0] exp_din;
    bit rd_rx;
    dmem_dout = $urandom;
    bios_dout = $urandom;
    #1;
    if (m_known) begin
      a     = bus.mem_adr;
      rd_rx = io_at(a, 1) && bus.wea == 4'h0;
      case (m_region)
        4'h1:    exp_din = dmem_dout;
        4'h4:    exp_din = bios_dout;
        4'h8:    exp_din = m_io;
        default: exp_din = 32'h0;
      endcase
      chk("din", bus.din, exp_din);
      chk("dmem_addr", 32'(dmem_addr), 32'(a[AW+1:2]));
      chk("imem_addr", 32'(imem_addr), 32'(a[AW+1:2]));
      chk("bios_addr", 32'(bios_addr), 32'(a[AW+1:2]));
      chk("dmem_we", 32'(dmem_we), 32'((a[31:28] == 4'h1) ? bus.wea : 4'h0));
      chk("imem_we", 32'(imem_we), 32'((a[31:28] == 4'h2 && pc[30]) ? bus.wea : 4'h0));
      chk("dmem_wdata", dmem_wdata, bus.mem_wdata);
      chk("imem_wdata", imem_wdata, bus.mem_wdata);
      chk("tx_valid", 32'(tx_valid), 32'(m_txq.size() != 0));
      if (m_txq.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_txq[0]));
      chk("rx_ready", 32'(rx_ready), 32'(!m_rx_full || rd_rx));
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.mem_adr   = a;
    bus.mem_wdata = d;
    bus.wea       = w;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {4'h1, 12'h0, r[15:2], 2'b00};
      1: return {4'h2, 12'h0, r[15:2], 2'b00};
      2: return {4'h4, 12'h0, r[15:2], 2'b00};
      3, 4: return 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
      default: return {4'h3, 28'h0} + 32'({$urandom_range(0, 3), 30'h0});
    endcase
  endfunction

  initial begin
    reset = 1'b1; pc = 32'h4000_0000; instr_retire = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
    dmem_dout = 32'h0; bios_dout = 32'h0;
    drive(32'h0, 32'h0, 4'h0);
    @(negedge clk);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_din", bus.din, 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    cyc();

    // dmem store then load
    drive(32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t1_dmem_we", 32'(dmem_we), 32'hF);
    chk("t1_dmem_addr", 32'(dmem_addr), 32'd4);
    cyc();
    drive(32'h1000_0010, 32'h0, 4'h0); cyc();
    drive(32'h0, 32'h0, 4'h0); cyc();

    // imem write gating on pc[30]
    pc = 32'h4000_0100;
    drive(32'h2000_0000, 32'h1234_5678, 4'hF);
    #1; chk("t2_imem_we_on", 32'(imem_we), 32'hF);
    cyc();
    pc = 32'h1000_0000;
    #1; chk("t2_imem_we_off", 32'(imem_we), 32'h0);
    cyc();

    // TX overflow then drain
    for (int i = 0; i < 5; i++) begin
      drive(32'h8000_0008, 32'h10 + i, 4'h1);
      cyc();
    end
    drive(32'h8000_0000, 32'h0, 4'h0); cyc();
    drive(32'h0, 32'h0, 4'h0);
    #1; chk("t3_status_full", bus.din, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("t3_tx_order", 32'(tx_data), 32'h10 + i);
      cyc();
    end
    #1; chk("t3_tx_drained", 32'(tx_valid), 32'h0);
    cyc();

    // RX buffer, then pop coincident with a new byte
    rx_valid = 1'b1; rx_data = 8'h41; cyc();
    rx_valid = 1'b0;
    drive(32'h8000_0000, 32'h0, 4'h0); cyc();
    drive(32'h8000_0004, 32'h0, 4'h0);
    #1; chk("t4_status_rx", bus.din & 32'h2, 32'h2);
    cyc();
    drive(32'h8000_0000, 32'h0, 4'h0);
    #1; chk("t4_rx_byte", bus.din, 32'h41);
    cyc();
    drive(32'h0, 32'h0, 4'h0);
    #1; chk("t4_status_empty", bus.din & 32'h2, 32'h0);
    cyc();
    rx_valid = 1'b1; rx_data = 8'h55; cyc();
    rx_data = 8'h42;
    drive(32'h8000_0004, 32'h0, 4'h0);
    #1; chk("t4_rx_ready_pop", 32'(rx_ready), 32'h1);
    cyc();
    rx_valid = 1'b0;
    drive(32'h8000_0000, 32'h0, 4'h0);
    #1; chk("t4_first_byte", bus.din, 32'h55);
    cyc();
    drive(32'h8000_0004, 32'h0, 4'h0);
    #1; chk("t4_still_full", bus.din & 32'h2, 32'h2);
    cyc();
    drive(32'h0, 32'h0, 4'h0);
    #1; chk("t4_second_byte", bus.din, 32'h42);
    cyc();

    // counters
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i < 60);
      cyc();
    end
    instr_retire = 1'b0;
    drive(32'h8000_0010, 32'h0, 4'h0); cyc();
    drive(32'h8000_0014, 32'h0, 4'h0);
    #1; chk("t5_cycle", bus.din, 32'd100);
    cyc();
    drive(32'h8000_0018, 32'h1, 4'hF);
    #1; chk("t5_instret", bus.din, 32'd60);
    cyc();
    drive(32'h8000_0010, 32'h0, 4'h0); cyc();
    drive(32'h8000_0014, 32'h0, 4'h0);
    #1; chk("t5_cycle_clr", bus.din, 32'h0);
    cyc();
    drive(32'h0, 32'h0, 4'h0);
    #1; chk("t5_instret_clr", bus.din, 32'h0);
    cyc();

    // reset mid-TX with a buffered RX byte
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h8000_0008, 32'hA0 + i, 4'hF);
      cyc();
    end
    rx_valid = 1'b1; rx_data = 8'h77;
    drive(32'h8000_0000, 32'h0, 4'h0); cyc();
    rx_valid = 1'b0;
    drive(32'h0, 32'h0, 4'h0);
    reset = 1'b1; cyc(); reset = 1'b0;
    #1;
    chk("t6_tx_valid", 32'(tx_valid), 32'h0);
    chk("t6_rx_ready", 32'(rx_ready), 32'h1);
    chk("t6_din", bus.din, 32'h0);
    cyc();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(rand_addr(), $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      pc           = $urandom;
      instr_retire = 1'($urandom_range(0, 1));
      tx_ready     = ($urandom_range(0, 3) == 0);
      rx_valid     = 1'($urandom_range(0, 1));
      rx_data      = 8'($urandom);
      reset        = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
